mux_lut_pipe: RTL and testbench
===============================

# mux_lut_pipe

Parametrised, pipelined lookup-table unit built from 2:1 mux trees. Each of `W` lanes evaluates the same run-time-programmable `K`-input boolean function. One registered mux level per input bit. The truth table is loaded serially into a shadow register and committed atomically. This is the general successor to fixed gates built from muxes and constants, and it sits between a valid/ready producer and consumer.

## Interface
- `K`, default 2: inputs per function; table size `N = 2**K`; `K >= 1`.
- `W`, default 4: number of independent lanes sharing one table.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `cfg_valid  in  1`: one table bit presented this cycle.
- `cfg_bit  in  1`: table bit, index 0 first.
- `cfg_done  out  1`: one-cycle pulse; new table committed.
- `in_valid  in  1`: input beat valid.
- `in_ready  out  1`: unit accepts beat.
- `in_data  in  W*K`: lane `i` select = `in_data[i*K +: K]`.
- `out_valid  out  1`: result valid.
- `out_ready  in  1`: consumer accepts result.
- `out_data  out  W`: lane `i` result = `table[sel_i]`.

## Operation
- Reset: the active table is set to AND (`N'b1` at index `N-1` only, all other entries 0). The shadow register, the bit counter (`$clog2(N)+1` bits) and all pipeline valids clear. `cfg_done=0`, `out_valid=0`, `out_data=0`.
- Config load:
  - Each `cfg_valid` cycle shifts `cfg_bit` into the shadow register and increments the counter.
  - On the N-th bit, the shadow (including that bit) is copied to the active table at the same edge, and the counter clears.
  - `cfg_done` is registered high for the following cycle.
  - A partial load never alters the active table.
- Datapath: K stages; stage `s` (1..K) resolves select bit `s-1`.
  - Stage 1 muxes table pairs by bit 0 into `N/2` registered partials per lane, and registers the remaining select bits.
  - Each later stage halves its partials.
  - Stage K output is `out_data`.
  - The table is read only at stage 1, so each beat uses the table active at the edge it enters.
- Flow control: `stall = out_valid & ~out_ready`; `in_ready = ~stall`.
  - On stall, all stages hold.
  - Otherwise all stages advance, and bubbles propagate as cleared valids.
  - A beat is accepted when `in_valid & in_ready`.
- The config load is independent of `stall`; it is never backpressured.

## Timing
- Latency: a beat accepted at edge `t` produces `out_valid` after edge `t+K-1`, i.e. visible in the cycle following the K-th edge. For K=2, data is visible 2 cycles after acceptance.
- Throughput: one beat per cycle when `out_ready` is held high.
- `out_data` and `out_valid` are held stable while stalled.
- `cfg_done` asserts 1 cycle after the edge that sampled the N-th bit.
- Simultaneous commit and acceptance at the same edge: the beat uses the OLD table.
- Asynchronous reset mid-load or mid-stream: the partial load is discarded and in-flight beats are dropped. No `out_valid` appears until new beats are accepted after reset release.
- Counter wrap: exactly N bits form a load; the N+1-th bit starts the next load.

## Configuration
- `MUX_LUT_READBACK_EN` defined: adds output port `active_table  out  N`, a registered copy of the committed table that resets to the AND pattern.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Default table, K=2, W=4, `out_ready=1`: after reset, `in_data=8'b11_10_01_11` -> `out_data=4'b1001` two cycles after acceptance.
- Load OR (bits 0,1,1,1) -> `cfg_done` pulse one cycle after the 4th bit. Then `in_data=8'b00_10_01_00` -> `out_data=4'b0110`.
- Backpressure: stream 4 distinct beats with `out_ready=0` for 3 cycles mid-stream -> `in_ready` low while stalled, `out_data` stable, all 4 results delivered in order with none lost or duplicated.
- Commit collision: the 4th XOR cfg bit (0,1,1,0) and beat `8'b11_11_11_11` are accepted at the same edge -> result `4'b1111` (old AND). The next identical beat -> `4'b0000`.
- Reset mid-load: load 2 bits, pulse `rst_n` low asynchronously -> `cfg_done` never pulses and the AND table is in effect. A fresh 4-bit load is then required for a commit.
- With `MUX_LUT_READBACK_EN`: `active_table=4'b1000` after reset, and `4'b1110` the cycle after the OR commit.

Source files
------------

// File: rtl/mux_lut_pipe.sv
// mux_lut_pipe
// -----------------------------------------------------------------------------
// Pipelined lookup-table unit built from 2:1 mux trees. W lanes share one
// run-time-programmable K-input truth table of N = 2**K entries. The table is
// shifted in serially, index 0 first, into a shadow register. It is committed
// atomically to the active table on the N-th bit. The datapath has one
// registered mux level per select bit and sits between a valid/ready
// producer and consumer.
//
// Parameters:
//   K            inputs per function (K >= 1), table size N = 2**K
//   W            number of independent lanes
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_valid    a table bit is presented this cycle
//   cfg_bit      table bit value, index 0 first
//   cfg_done     one-cycle pulse after a new table has been committed
//   in_valid     input beat valid
//   in_ready     unit accepts a beat (low only while the output is stalled)
//   in_data      lane i select = in_data[i*K +: K]
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     lane i result = table[select_i]
//   active_table (only with MUX_LUT_READBACK_EN) committed table copy
//
// Build option: define MUX_LUT_READBACK_EN to add the active_table port.
// -----------------------------------------------------------------------------
module mux_lut_pipe #(
    parameter int K = 2,
    parameter int W = 4,
    localparam int N  = 1 << K,
    localparam int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    input  logic           cfg_bit,
    output logic           cfg_done,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*K-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
`ifdef MUX_LUT_READBACK_EN
    ,
    output logic [N-1:0]   active_table
`endif
);

    // Reset table is AND: only the all-ones select yields 1.
    localparam logic [N-1:0] AND_TABLE = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]  tbl_q;
    logic [N-1:0]  shadow;
    logic [N-1:0]  shadow_next;
    logic [CW-1:0] bit_cnt;
    logic          stall;

    // The incoming bit lands at the position given by the counter, so the
    // shadow including the current bit is available for a same-edge commit.
    for (genvar i = 0; i < N; i++) begin : g_shadow
        assign shadow_next[i] = (bit_cnt == CW'(i)) ? cfg_bit : shadow[i];
    end

    // Serial table load; never backpressured, independent of the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            bit_cnt  <= '0;
            tbl_q    <= AND_TABLE;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_valid) begin
                shadow <= shadow_next;
                if (bit_cnt == CW'(N - 1)) begin
                    tbl_q    <= shadow_next;
                    bit_cnt  <= '0;
                    cfg_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage s holds, per lane, N>>s partial results in its low bits followed by
    // the K-s select bits still to be resolved. Stage 1 sees the table itself
    // as its N "partials", so every stage has the same mux structure.
    for (genvar s = 1; s <= K; s++) begin : g_stage
        localparam int P  = N >> s;
        localparam int L  = P + K - s;
        localparam int PI = 2 * P;
        localparam int LI = PI + K - s + 1;

        logic [W*LI-1:0] din;
        logic            vin;
        logic [W*L-1:0]  dnext;
        logic [W*L-1:0]  q;
        logic            vq;

        if (s == 1) begin : g_src
            // The table is only read here, so a beat uses the table active at
            // the edge it enters, even if a commit happens at that same edge.
            for (genvar i = 0; i < W; i++) begin : g_lane_in
                assign din[i*LI +: LI] = {in_data[i*K +: K], tbl_q};
            end
            assign vin = in_valid & in_ready;
        end else begin : g_src
            assign din = g_stage[s-1].q;
            assign vin = g_stage[s-1].vq;
        end

        for (genvar i = 0; i < W; i++) begin : g_lane
            for (genvar j = 0; j < P; j++) begin : g_part
                assign dnext[i*L + j] = din[i*LI + PI] ? din[i*LI + 2*j + 1]
                                                       : din[i*LI + 2*j];
            end
            for (genvar b = 0; b < K - s; b++) begin : g_sel
                assign dnext[i*L + P + b] = din[i*LI + PI + 1 + b];
            end
        end

        // Whole pipeline holds on stall; otherwise bubbles move as cleared valids.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q  <= '0;
                vq <= 1'b0;
            end else if (!stall) begin
                q  <= dnext;
                vq <= vin;
            end
        end
    end

    assign out_data  = g_stage[K].q;
    assign out_valid = g_stage[K].vq;

`ifdef MUX_LUT_READBACK_EN
    assign active_table = tbl_q;
`else
    // Without readback the committed table is only observable through out_data.
`endif

endmodule

// File: tb/tb_mux_lut_pipe.sv
// tb_mux_lut_pipe
// -----------------------------------------------------------------------------
// Self-checking bench for mux_lut_pipe (K=2, W=4). A behavioural model keeps
// the committed table as a plain bit vector, the pipeline as a K-entry queue of
// results, and the load progress as a bit count. Directed scenarios are
// followed by a randomized stretch that includes an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mux_lut_pipe;

    localparam int K = 2;
    localparam int W = 4;
    localparam int N = 1 << K;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_bit = 1'b0;
    logic           in_valid = 1'b0;
    logic [W*K-1:0] in_data = '0;
    logic           out_ready = 1'b1;
    logic           cfg_done;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
`ifdef MUX_LUT_READBACK_EN
    logic [N-1:0]   active_table;
`endif

    always #5 clk = ~clk;

    mux_lut_pipe #(.K(K), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MUX_LUT_READBACK_EN
        ,
        .active_table (active_table)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [N-1:0] mTbl;
    logic [N-1:0] mShadow;
    int           mCnt;
    logic         mDone;
    logic         mV[$];
    logic [W-1:0] mD[$];
    logic [W-1:0] gotQ[$];

    function automatic logic [W-1:0] lutEval(input logic [N-1:0] tbl,
                                             input logic [W*K-1:0] d);
        logic [W-1:0] r;
        logic [K-1:0] sel;
        for (int i = 0; i < W; i++) begin
            sel  = d[i*K +: K];
            r[i] = tbl[sel];
        end
        return r;
    endfunction

    function automatic logic modelStall(input logic ordy);
        return mV[0] && !ordy;
    endfunction

    task automatic modelReset();
        mTbl    = '0;
        mTbl[N-1] = 1'b1;
        mShadow = '0;
        mCnt    = 0;
        mDone   = 1'b0;
        mV.delete();
        mD.delete();
        for (int i = 0; i < K; i++) begin
            mV.push_back(1'b0);
            mD.push_back('0);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic modelEdge();
        if (!modelStall(out_ready)) begin
            void'(mV.pop_front());
            void'(mD.pop_front());
            mV.push_back(in_valid);
            mD.push_back(lutEval(mTbl, in_data));
        end
        mDone = 1'b0;
        if (cfg_valid) begin
            mShadow[mCnt] = cfg_bit;
            mCnt++;
            if (mCnt == N) begin
                mTbl  = mShadow;
                mCnt  = 0;
                mDone = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCycle();
        checkOutput("out_valid", 32'(out_valid), 32'(mV[0]));
        if (mV[0]) checkOutput("out_data", 32'(out_data), 32'(mD[0]));
        checkOutput("in_ready", 32'(in_ready), 32'(!modelStall(out_ready)));
        checkOutput("cfg_done", 32'(cfg_done), 32'(mDone));
`ifdef MUX_LUT_READBACK_EN
        checkOutput("active_table", 32'(active_table), 32'(mTbl));
`endif
    endtask

    // Drive one cycle of inputs, log any delivered result, clock, then check.
    task automatic applyStimulus(input logic cv, input logic cb, input logic iv,
                                 input logic [W*K-1:0] id, input logic ordy);
        cfg_valid = cv;
        cfg_bit   = cb;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) gotQ.push_back(out_data);
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_data", 32'(out_data), 32'd0);
        checkOutput("arst_cfg_done", 32'(cfg_done), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W*K-1:0] beats [4];
        logic           orBits [4];
        logic           xorBits [4];
        logic           ordy;
        logic           iv;
        logic           acc;
        logic           dup;
        int             idx;

        orBits  = '{1'b0, 1'b1, 1'b1, 1'b1};
        xorBits = '{1'b0, 1'b1, 1'b1, 1'b0};

        // Power-on reset.
        modelReset();
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MUX_LUT_READBACK_EN
        checkOutput("rst_active_table", 32'(active_table), 32'b1000);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Default AND table.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'b11_10_01_11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("and_valid", 32'(out_valid), 32'd1);
        checkOutput("and_data", 32'(out_data), 32'b1001);
        idle(2);

        // Load OR.
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, orBits[i], 1'b0, '0, 1'b1);
            if (i == N - 2) checkOutput("or_done_early", 32'(cfg_done), 32'd0);
        end
        checkOutput("or_done", 32'(cfg_done), 32'd1);
`ifdef MUX_LUT_READBACK_EN
        checkOutput("or_active_table", 32'(active_table), 32'b1110);
`endif
        idle(1);
        checkOutput("or_done_pulse", 32'(cfg_done), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'b00_10_01_00, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("or_data", 32'(out_data), 32'b0110);
        idle(2);

        // Backpressure: four distinct beats, consumer stalls for three cycles.
        for (int i = 0; i < 4; i++) begin
            do begin
                beats[i] = (W*K)'($urandom);
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (beats[j] == beats[i]) dup = 1'b1;
            end while (dup);
        end
        gotQ.delete();
        idx = 0;
        for (int step = 0; step < 12; step++) begin
            ordy = !(step >= 2 && step <= 4);
            iv   = (idx < 4);
            acc  = iv && !modelStall(ordy);
            applyStimulus(1'b0, 1'b0, iv, iv ? beats[idx] : '0, ordy);
            if (step == 3) checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (acc) idx++;
        end
        checkOutput("bp_count", 32'(gotQ.size()), 32'd4);
        for (int i = 0; i < 4 && i < gotQ.size(); i++)
            checkOutput("bp_order", 32'(gotQ[i]), 32'(lutEval(4'b1110, beats[i])));

        // Reset in the middle of a load.
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        doReset();
        idle(3);
        checkOutput("rstload_done", 32'(cfg_done), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'b11_10_01_11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("rstload_and", 32'(out_data), 32'b1001);
        idle(1);

        // Commit and acceptance at the same edge: beat uses the old table.
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, xorBits[i], 1'b0, '0, 1'b1);
        checkOutput("xor_done_early", 32'(cfg_done), 32'd0);
        applyStimulus(1'b1, xorBits[N-1], 1'b1, 8'hFF, 1'b1);
        checkOutput("xor_done", 32'(cfg_done), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        checkOutput("collide_old", 32'(out_data), 32'b1111);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("collide_new", 32'(out_data), 32'b0000);
        idle(1);

        // Randomized traffic, loads of random tables, one mid-stream reset.
        for (int c = 0; c < 300; c++) begin
            if (c == 150) doReset();
            applyStimulus($urandom_range(0, 2) == 0, 1'($urandom),
                          $urandom_range(0, 3) != 0, (W*K)'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
